vid_timing_gen: RTL and testbench

- Parametrised successor to the fixed 1440x900 text-screen timing logic.
- Generates hsync/vsync, active-area flags, pixel/line counters and character-cell coordinates, all in one clock domain; vsync is not derived from an hsync edge.
- Adds programmable sync polarity, parametrised cell geometry, a cell prefetch strobe with configurable lead (including wrap to column 0 of the next line), start-of-line/frame pulses, a blink divider and cursor-hit decode.
- Feeds the text renderer, the font ROM and the screen RAM read side.

---
 rtl/vid_timing_gen.sv | 202 ++++++++++++++++++++
 tb/tb_vid_timing_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_timing_gen.sv
// Raster timing generator: sync, active flags, counters, cell coordinates, prefetch strobe, blink and cursor decode.
// Every output is registered and describes the same pixel (zero skew); free-running, no backpressure.
module vid_timing_gen #(
    parameter int H_ACTIVE     = 1440,
    parameter int H_FP         = 80,
    parameter int H_SYNC       = 152,
    parameter int H_BP         = 232,
    parameter int V_ACTIVE     = 900,
    parameter int V_FP         = 3,
    parameter int V_SYNC       = 6,
    parameter int V_BP         = 25,
    parameter int HS_POL       = 1,
    parameter int VS_POL       = 1,
    parameter int CNT_W        = 12,
    parameter int CELL_W_LOG2  = 4,
    parameter int CELL_H_LOG2  = 4,
    parameter int FETCH_LEAD   = 4,
    parameter int CURSOR_START = 11,
    parameter int BLINK_LOG2   = 5
) (
    input  logic                          pixel_clock_i,
    input  logic                          reset_n_i,
    input  logic                          enable_i,
    input  logic                          cur_we_i,
    input  logic [CNT_W-CELL_W_LOG2-1:0]  cur_col_i,
    input  logic [CNT_W-CELL_H_LOG2-1:0]  cur_row_i,
    output logic                          hsync_o,
    output logic                          vsync_o,
    output logic                          visible_o,
    output logic [CNT_W-1:0]              pixel_x_o,
    output logic [CNT_W-1:0]              line_y_o,
    output logic [CNT_W-CELL_W_LOG2-1:0]  cell_col_o,
    output logic [CNT_W-CELL_H_LOG2-1:0]  cell_row_o,
    output logic [CELL_H_LOG2-1:0]        cell_ln_o,
    output logic                          sol_o,
    output logic                          sof_o,
    output logic                          fetch_stb_o,
    output logic [CNT_W-CELL_W_LOG2-1:0]  fetch_col_o,
    output logic [CNT_W-CELL_H_LOG2-1:0]  fetch_row_o,
    output logic [CELL_H_LOG2-1:0]        fetch_ln_o,
    output logic                          blink_o,
    output logic                          cursor_hit_o
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CC_W  = CNT_W - CELL_W_LOG2;
    localparam int CR_W  = CNT_W - CELL_H_LOG2;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W:0]   H_TOT_X = (CNT_W+1)'(H_TOT);
    localparam logic [CNT_W:0]   H_ACT_X = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   LEAD_X  = (CNT_W+1)'(FETCH_LEAD);
    localparam logic [CELL_H_LOG2-1:0] CUR_ST = CELL_H_LOG2'(CURSOR_START);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic                   run_q,   run_d;
    logic [CNT_W-1:0]       px_q,    px_d;
    logic [CNT_W-1:0]       ly_q,    ly_d;
    logic [BLINK_LOG2-1:0]  frame_q, frame_d;
    logic [CC_W-1:0]        ccol_q,  ccol_d;
    logic [CR_W-1:0]        crow_q,  crow_d;
    logic                   hs_q,    hs_d;
    logic                   vs_q,    vs_d;
    logic                   vis_q,   vis_d;
    logic                   sol_q,   sol_d;
    logic                   sof_q,   sof_d;
    logic                   fstb_q,  fstb_d;
    logic [CC_W-1:0]        fcol_q,  fcol_d;
    logic [CR_W-1:0]        frow_q,  frow_d;
    logic [CELL_H_LOG2-1:0] fln_q,   fln_d;
    logic                   hit_q,   hit_d;

    logic [CNT_W:0]         t_sum;
    logic [CNT_W:0]         t_cell;
    logic                   t_wrap;
    logic [CNT_W-1:0]       tgt_ln;

    // Everything is computed from the position about to be presented, so one register stage aligns all outputs.
    always_comb begin
        run_d = enable_i;
        px_d  = '0;
        ly_d  = '0;
        if (enable_i && run_q) begin
            if (px_q == H_LAST) begin
                if (ly_q == V_LAST) begin
                    ly_d = '0;
                end else begin
                    ly_d = ly_q + 1'b1;
                end
            end else begin
                px_d = px_q + 1'b1;
                ly_d = ly_q;
            end
        end

        vis_d   = enable_i && (px_d < H_ACT) && (ly_d < V_ACT);
        hs_d    = (enable_i && (px_d >= HS_BEG) && (px_d < HS_END)) ? HS_ON : ~HS_ON;
        vs_d    = (enable_i && (ly_d >= VS_BEG) && (ly_d < VS_END)) ? VS_ON : ~VS_ON;
        sol_d   = enable_i && (px_d == '0);
        sof_d   = sol_d && (ly_d == '0);
        frame_d = frame_q + BLINK_LOG2'(sof_d);

        // Lead past the end of the line targets column 0 of the following line.
        t_sum  = {1'b0, px_d} + LEAD_X;
        t_wrap = (t_sum >= H_TOT_X);
        t_cell = t_wrap ? (t_sum - H_TOT_X) : t_sum;
        if (!t_wrap) begin
            tgt_ln = ly_d;
        end else if (ly_d == V_LAST) begin
            tgt_ln = '0;
        end else begin
            tgt_ln = ly_d + 1'b1;
        end
        fstb_d = enable_i && (t_cell[CELL_W_LOG2-1:0] == '0) && (t_cell < H_ACT_X) && (tgt_ln < V_ACT);

        fcol_d = fcol_q;
        frow_d = frow_q;
        fln_d  = fln_q;
        if (!enable_i) begin
            fcol_d = '0;
            frow_d = '0;
            fln_d  = '0;
        end else if (fstb_d) begin
            fcol_d = t_cell[CNT_W-1:CELL_W_LOG2];
            frow_d = tgt_ln[CNT_W-1:CELL_H_LOG2];
            fln_d  = tgt_ln[CELL_H_LOG2-1:0];
        end

        ccol_d = cur_we_i ? cur_col_i : ccol_q;
        crow_d = cur_we_i ? cur_row_i : crow_q;
        hit_d  = vis_d
              && (px_d[CNT_W-1:CELL_W_LOG2] == ccol_d)
              && (ly_d[CNT_W-1:CELL_H_LOG2] == crow_d)
              && (ly_d[CELL_H_LOG2-1:0] >= CUR_ST)
              && frame_d[BLINK_LOG2-1];
    end

    always_ff @(posedge pixel_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            run_q   <= 1'b0;
            px_q    <= '0;
            ly_q    <= '0;
            frame_q <= '0;
            ccol_q  <= '1;
            crow_q  <= '1;
            hs_q    <= ~HS_ON;
            vs_q    <= ~VS_ON;
            vis_q   <= 1'b0;
            sol_q   <= 1'b0;
            sof_q   <= 1'b0;
            fstb_q  <= 1'b0;
            fcol_q  <= '0;
            frow_q  <= '0;
            fln_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            run_q   <= run_d;
            px_q    <= px_d;
            ly_q    <= ly_d;
            frame_q <= frame_d;
            ccol_q  <= ccol_d;
            crow_q  <= crow_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            vis_q   <= vis_d;
            sol_q   <= sol_d;
            sof_q   <= sof_d;
            fstb_q  <= fstb_d;
            fcol_q  <= fcol_d;
            frow_q  <= frow_d;
            fln_q   <= fln_d;
            hit_q   <= hit_d;
        end
    end

    assign hsync_o      = hs_q;
    assign vsync_o      = vs_q;
    assign visible_o    = vis_q;
    assign pixel_x_o    = px_q;
    assign line_y_o     = ly_q;
    assign cell_col_o   = px_q[CNT_W-1:CELL_W_LOG2];
    assign cell_row_o   = ly_q[CNT_W-1:CELL_H_LOG2];
    assign cell_ln_o    = ly_q[CELL_H_LOG2-1:0];
    assign sol_o        = sol_q;
    assign sof_o        = sof_q;
    assign fetch_stb_o  = fstb_q;
    assign fetch_col_o  = fcol_q;
    assign fetch_row_o  = frow_q;
    assign fetch_ln_o   = fln_q;
    assign blink_o      = frame_q[BLINK_LOG2-1];
    assign cursor_hit_o = hit_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: small raster, model indexed by absolute cycle since enable, plus literal spot checks.
module tb_vid_timing_gen;

    localparam int CW = 8, HT = 24, VT = 12, HA = 16, VA = 8, LEAD = 2, BL = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       cur_we = 1'b0;
    logic [5:0] cur_col = '0;
    logic [5:0] cur_row = '0;

    logic       hsync, vsync, visible, sol, sof, fetch_stb, blink, cursor_hit;
    logic [7:0] pixel_x, line_y;
    logic [5:0] cell_col, cell_row, fetch_col, fetch_row;
    logic [1:0] cell_ln, fetch_ln;

    logic       b_hsync, b_vsync, b_visible, b_sol, b_sof, b_fetch_stb, b_blink, b_cursor_hit;
    logic [7:0] b_pixel_x, b_line_y;
    logic [5:0] b_cell_col, b_cell_row, b_fetch_col, b_fetch_row;
    logic [1:0] b_cell_ln, b_fetch_ln;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vid_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1), .VS_POL(1), .CNT_W(CW), .CELL_W_LOG2(2), .CELL_H_LOG2(2),
        .FETCH_LEAD(LEAD), .CURSOR_START(3), .BLINK_LOG2(BL)
    ) dut (
        .pixel_clock_i(clk), .reset_n_i(rst_n), .enable_i(enable), .cur_we_i(cur_we),
        .cur_col_i(cur_col), .cur_row_i(cur_row),
        .hsync_o(hsync), .vsync_o(vsync), .visible_o(visible), .pixel_x_o(pixel_x), .line_y_o(line_y),
        .cell_col_o(cell_col), .cell_row_o(cell_row), .cell_ln_o(cell_ln), .sol_o(sol), .sof_o(sof),
        .fetch_stb_o(fetch_stb), .fetch_col_o(fetch_col), .fetch_row_o(fetch_row), .fetch_ln_o(fetch_ln),
        .blink_o(blink), .cursor_hit_o(cursor_hit)
    );

    vid_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(0), .VS_POL(0), .CNT_W(CW), .CELL_W_LOG2(2), .CELL_H_LOG2(2),
        .FETCH_LEAD(LEAD), .CURSOR_START(3), .BLINK_LOG2(BL)
    ) dut_neg (
        .pixel_clock_i(clk), .reset_n_i(rst_n), .enable_i(enable), .cur_we_i(cur_we),
        .cur_col_i(cur_col), .cur_row_i(cur_row),
        .hsync_o(b_hsync), .vsync_o(b_vsync), .visible_o(b_visible), .pixel_x_o(b_pixel_x), .line_y_o(b_line_y),
        .cell_col_o(b_cell_col), .cell_row_o(b_cell_row), .cell_ln_o(b_cell_ln), .sol_o(b_sol), .sof_o(b_sof),
        .fetch_stb_o(b_fetch_stb), .fetch_col_o(b_fetch_col), .fetch_row_o(b_fetch_row), .fetch_ln_o(b_fetch_ln),
        .blink_o(b_blink), .cursor_hit_o(b_cursor_hit)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model state: absolute cycle index since the run started, frames seen, cursor and held fetch target.
    bit m_run = 0;
    int m_n = 0, m_frames = 0;
    int m_ccol = 63, m_crow = 63;
    int m_fcol = 0, m_frow = 0, m_fln = 0;

    task automatic fetch_of(input int x, input int y, output bit stb, output int col, output int row, output int ln);
        int s, t, tl;
        s   = x + LEAD;
        tl  = (s >= HT) ? (y + 1) % VT : y;
        t   = s % HT;
        stb = (t % 4 == 0) && (t < HA) && (tl < VA);
        col = t / 4;
        row = tl / 4;
        ln  = tl % 4;
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit s; int c, r, l;
        if (!rst_n) begin
            m_run = 0; m_n = 0; m_frames = 0;
            m_ccol = 63; m_crow = 63;
            m_fcol = 0; m_frow = 0; m_fln = 0;
        end else begin
            if (cur_we) begin
                m_ccol = int'(cur_col);
                m_crow = int'(cur_row);
            end
            if (!enable) begin
                m_run = 0; m_n = 0;
                m_fcol = 0; m_frow = 0; m_fln = 0;
            end else begin
                if (m_run) m_n++;
                else begin
                    m_run = 1;
                    m_n = 0;
                end
                if (m_n % (HT * VT) == 0) m_frames++;
                fetch_of(m_n % HT, (m_n / HT) % VT, s, c, r, l);
                if (s) begin
                    m_fcol = c; m_frow = r; m_fln = l;
                end
            end
        end
    end

    // Per-frame/per-line statistics measured from the DUT, checked later against literals.
    int cyc = 0, last_sof = 0, sof_per = 0, last_sol = 0, sol_per = 0;
    int vis_cnt = 0, vis_frame = 0, vs_cnt = 0, vs_frame = 0, vsb_cnt = 0, vsb_frame = 0;
    int hs_cnt = 0, hs_line = 0;

    always @(negedge clk) begin
        int x, y, e_vis, e_hs, e_vs, e_blink, c, r, l;
        bit s;
        x = m_run ? m_n % HT : 0;
        y = m_run ? (m_n / HT) % VT : 0;
        e_vis   = (m_run && x < HA && y < VA) ? 1 : 0;
        e_hs    = (m_run && x >= 18 && x < 20) ? 1 : 0;
        e_vs    = (m_run && y == 9) ? 1 : 0;
        e_blink = ((m_frames % (1 << BL)) >> (BL - 1)) & 1;
        fetch_of(x, y, s, c, r, l);
        chk("pixel_x", int'(pixel_x), x);
        chk("line_y", int'(line_y), y);
        chk("hsync", int'(hsync), e_hs);
        chk("vsync", int'(vsync), e_vs);
        chk("visible", int'(visible), e_vis);
        chk("cell_col", int'(cell_col), x / 4);
        chk("cell_row", int'(cell_row), y / 4);
        chk("cell_ln", int'(cell_ln), y % 4);
        chk("sol", int'(sol), (m_run && x == 0) ? 1 : 0);
        chk("sof", int'(sof), (m_run && x == 0 && y == 0) ? 1 : 0);
        chk("fetch_stb", int'(fetch_stb), (m_run && s) ? 1 : 0);
        chk("fetch_col", int'(fetch_col), m_fcol);
        chk("fetch_row", int'(fetch_row), m_frow);
        chk("fetch_ln", int'(fetch_ln), m_fln);
        chk("blink", int'(blink), e_blink);
        chk("cursor_hit", int'(cursor_hit),
            (e_vis == 1 && x / 4 == m_ccol && y / 4 == m_crow && y % 4 >= 3 && e_blink == 1) ? 1 : 0);
        chk("neg_hsync", int'(b_hsync), 1 - e_hs);
        chk("neg_vsync", int'(b_vsync), 1 - e_vs);

        cyc++;
        if (sof) begin
            sof_per = cyc - last_sof; last_sof = cyc;
            vis_frame = vis_cnt; vis_cnt = 0;
            vs_frame = vs_cnt; vs_cnt = 0;
            vsb_frame = vsb_cnt; vsb_cnt = 0;
        end
        if (sol) begin
            sol_per = cyc - last_sol; last_sol = cyc;
            hs_line = hs_cnt; hs_cnt = 0;
        end
        vis_cnt += int'(visible);
        vs_cnt  += int'(vsync);
        vsb_cnt += int'(!b_vsync);
        hs_cnt  += int'(hsync);
    end

    task automatic wait_pos(input int x, input int y);
        int k = 0;
        @(negedge clk);
        while (!(int'(pixel_x) == x && int'(line_y) == y) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("wait_pos_x", int'(pixel_x), x);
        chk("wait_pos_y", int'(line_y), y);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hsync", int'(hsync), 0);
        chk("rst_neg_hsync", int'(b_hsync), 1);
        chk("rst_neg_vsync", int'(b_vsync), 1);
        chk("rst_visible", int'(visible), 0);

        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        chk("first_px", int'(pixel_x), 0);
        chk("first_sol", int'(sol), 1);
        chk("first_sof", int'(sof), 1);
        chk("first_blink", int'(blink), 1);

        wait_pos(22, 0);
        chk("l0_wrap_stb", int'(fetch_stb), 1);
        chk("l0_wrap_col", int'(fetch_col), 0);
        chk("l0_wrap_row", int'(fetch_row), 0);
        chk("l0_wrap_ln", int'(fetch_ln), 1);

        wait_pos(22, 7);
        chk("l7_no_stb", int'(fetch_stb), 0);
        cur_we  = 1'b1;
        cur_col = 6'd2;
        cur_row = 6'd1;
        @(negedge clk);
        cur_we = 1'b0;

        wait_pos(22, 11);
        chk("l11_stb", int'(fetch_stb), 1);
        chk("l11_ln", int'(fetch_ln), 0);

        wait_pos(9, 7);
        chk("f2_blink", int'(blink), 0);
        chk("f2_hit", int'(cursor_hit), 0);
        wait_pos(9, 7);
        chk("f3_hit", int'(cursor_hit), 1);
        wait_pos(12, 7);
        chk("f3_hit_col3", int'(cursor_hit), 0);

        wait_pos(9, 9);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_px", int'(pixel_x), 0);
        chk("dis_sol", int'(sol), 0);
        chk("dis_blink", int'(blink), 1);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_sof", int'(sof), 1);
        chk("reen_blink", int'(blink), 0);

        wait_pos(5, 3);
        wait_pos(5, 3);
        chk("sof_period", sof_per, 288);
        chk("sol_period", sol_per, 24);
        chk("vis_per_frame", vis_frame, 128);
        chk("vs_per_frame", vs_frame, 24);
        chk("neg_vs_per_frame", vsb_frame, 24);
        chk("hs_per_line", hs_line, 2);
        chk("f5_blink", int'(blink), 1);

        #2 rst_n = 1'b0;
        #1;
        chk("arst_px", int'(pixel_x), 0);
        chk("arst_visible", int'(visible), 0);
        chk("arst_blink", int'(blink), 0);
        chk("arst_neg_hsync", int'(b_hsync), 1);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
